// File: rtl/spi_pkg.sv
// Shared definitions for spi_transceiver: config bit positions, FSM state type
// and the baud-select to half-period helper.
package spi_pkg;

    localparam int CFG_MASTER   = 7;
    localparam int CFG_CPOL     = 6;
    localparam int CFG_CPHA     = 5;
    localparam int CFG_LSBF     = 4;
    localparam int CFG_IRQEN    = 3;
    localparam int CFG_BAUD_MSB = 2;
    localparam int CFG_BAUD_LSB = 0;

    localparam int HALF_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StDone
    } state_t;

    // SCK half-period in system clocks: 2^sel, so never below 1.
    function automatic logic [HALF_W-1:0] half_period(input logic [2:0] sel);
        logic [HALF_W-1:0] one;
        one = {{(HALF_W-1){1'b0}}, 1'b1};
        return one << sel;
    endfunction

endpackage

// File: rtl/spi_baud_gen.sv
// Free-running half-period counter; tick marks each SCK toggle point.
// clr holds the counter at zero so a transfer always starts on a full half-period.
module spi_baud_gen
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [HALF_W-1:0] half,
    output logic              tick
);

    logic [HALF_W-1:0] cnt_q, cnt_d;

    assign tick = en && !clr && ((cnt_q + HALF_W'(1)) == half);

    always_comb begin
        cnt_d = cnt_q + HALF_W'(1);
        if (clr || !en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_transceiver.sv
// Single-byte SPI master/slave transceiver with CPOL/CPHA, baud select and IRQ.
// Define SPI_LSB_FIRST_EN to honour config bit 4 (LSB-first); otherwise MSB-first only.
module spi_transceiver
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CFG_W  = 8
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CFG_W-1:0]  i_data_config,
    input  logic              i_trans_en,
    output logic              o_interrupt,
    output logic [DATA_W-1:0] o_data,
    inout  wire logic         io_MOSI,
    inout  wire logic         io_MISO,
    inout  wire logic         io_SCK,
    inout  wire logic         io_SS
);

    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam int EDGE_W = $clog2(2 * DATA_W);

    state_t              state_q, state_d;
    logic [CFG_W-1:0]    cfg_q;
    logic                switch_q;
    logic [DATA_W-1:0]   tx_q, tx_d, rx_q, rx_d, data_q;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic                sck_q, sck_d;
    logic                irq_q;
    logic                sck_meta, sck_s, sck_prev;
    logic                ss_meta, ss_s, ss_prev;
    logic                mosi_meta, mosi_s;

    logic master, cpol, cpha, lsbf;
    logic busy_m, tick, stay_idle;
    logic edge_evt, lead, sample, shift, rx_bit, tx_out;
    logic [DATA_W-1:0] tx_next, rx_next;

    assign master = cfg_q[CFG_MASTER];
    assign cpol   = cfg_q[CFG_CPOL];
    assign cpha   = cfg_q[CFG_CPHA];

`ifdef SPI_LSB_FIRST_EN
    assign lsbf = cfg_q[CFG_LSBF];
`else
    logic unused_lsbf;
    assign unused_lsbf = cfg_q[CFG_LSBF];
    assign lsbf        = 1'b0;
`endif

    assign busy_m = state_q inside {StSetup, StShift, StHold};

    spi_baud_gen u_baud (
        .clk   (i_sys_clk),
        .rst_n (i_sys_rst),
        .en    (master && busy_m),
        .clr   (state_q == StIdle),
        .half  (half_period(cfg_q[CFG_BAUD_MSB:CFG_BAUD_LSB])),
        .tick  (tick)
    );

    assign tx_out  = lsbf ? tx_q[0] : tx_q[DATA_W-1];
    assign tx_next = lsbf ? {1'b0, tx_q[DATA_W-1:1]} : {tx_q[DATA_W-2:0], 1'b0};
    assign rx_next = lsbf ? {rx_bit, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], rx_bit};

    // Master edges come from the baud tick, slave edges from the synchronised SCK.
    always_comb begin
        if (master) begin
            edge_evt = (state_q == StShift) && tick;
            lead     = !edge_q[0];
            rx_bit   = io_MISO;
        end else begin
            edge_evt = (state_q == StShift) && (sck_s != sck_prev);
            lead     = (sck_s != cpol);
            rx_bit   = mosi_s;
        end
        sample = edge_evt && (lead ^ cpha);
        // With CPHA=1 the first bit is already on the line before the first leading edge.
        shift  = edge_evt && !(lead ^ cpha) && !(cpha && (bit_q == '0));
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        edge_d  = edge_q;
        sck_d   = cpol;
        case (state_q)
            StIdle: begin
                tx_d   = i_trans_en ? i_data : '0;
                rx_d   = '0;
                bit_d  = '0;
                edge_d = '0;
                if (!switch_q) begin
                    if (master && i_trans_en) begin
                        state_d = StSetup;
                    end else if (!master && !ss_s && ss_prev) begin
                        state_d = StShift;
                    end
                end
            end
            StSetup: begin
                if (tick) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                sck_d = sck_q;
                if (master && tick) begin
                    sck_d  = !sck_q;
                    edge_d = edge_q + EDGE_W'(1);
                    if (edge_q == EDGE_W'(2 * DATA_W - 1)) begin
                        state_d = StHold;
                    end
                end
                if (sample) begin
                    rx_d  = rx_next;
                    bit_d = bit_q + BIT_W'(1);
                    if (!master && (bit_q == BIT_W'(DATA_W - 1))) begin
                        state_d = StDone;
                    end
                end
                if (shift) begin
                    tx_d = tx_next;
                end
                if (!master && ss_s) begin
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (tick) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign stay_idle = (state_q == StIdle) && (state_d == StIdle);

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q   <= StIdle;
            cfg_q     <= '0;
            switch_q  <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            data_q    <= '0;
            bit_q     <= '0;
            edge_q    <= '0;
            sck_q     <= 1'b0;
            irq_q     <= 1'b0;
            sck_meta  <= 1'b0;
            sck_s     <= 1'b0;
            sck_prev  <= 1'b0;
            ss_meta   <= 1'b1;
            ss_s      <= 1'b1;
            ss_prev   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            edge_q  <= edge_d;
            sck_q   <= sck_d;
            if (stay_idle) begin
                cfg_q <= i_data_config;
            end
            // One dead cycle on a master/slave swap so neither side fights the pads.
            switch_q <= stay_idle && (i_data_config[CFG_MASTER] != cfg_q[CFG_MASTER]);
            if (state_q == StDone) begin
                data_q <= rx_q;
            end
            irq_q     <= (state_q == StDone) && cfg_q[CFG_IRQEN];
            sck_meta  <= io_SCK;
            sck_s     <= sck_meta;
            sck_prev  <= sck_s;
            ss_meta   <= io_SS;
            ss_s      <= ss_meta;
            ss_prev   <= ss_s;
            mosi_meta <= io_MOSI;
            mosi_s    <= mosi_meta;
        end
    end

    assign o_data      = data_q;
    assign o_interrupt = irq_q;

    assign io_SCK  = (master && !switch_q) ? ((state_q == StShift) ? sck_q : cpol) : 1'bz;
    assign io_SS   = (master && !switch_q) ? !busy_m : 1'bz;
    assign io_MOSI = (master && !switch_q) ? (busy_m && tx_out) : 1'bz;
    assign io_MISO = (!master && !switch_q && !ss_s) ? tx_out : 1'bz;

endmodule

// File: tb/tb_spi_transceiver.sv
// Directed self-checking bench for spi_transceiver; pads carry pull-ups so an
// undriven pad reads 1. Define SPI_LSB_FIRST_EN to also run the LSB-first case.
module tb_spi_transceiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic [7:0] cfg;
    logic       trans_en;
    logic       irq;
    logic [7:0] data_out;

    wire sck_w, ss_w, mosi_w, miso_w;
    pullup (sck_w);
    pullup (ss_w);
    pullup (mosi_w);
    pullup (miso_w);

    // External master drive for slave-mode tests
    logic tb_drive = 1'b0;
    logic tb_sck   = 1'b0;
    logic tb_ss    = 1'b1;
    logic tb_mosi  = 1'b0;
    assign sck_w  = tb_drive ? tb_sck  : 1'bz;
    assign ss_w   = tb_drive ? tb_ss   : 1'bz;
    assign mosi_w = tb_drive ? tb_mosi : 1'bz;

    // Slave model / loopback feeding MISO in master-mode tests
    logic       loop_en  = 1'b0;
    logic       model_en = 1'b0;
    logic [7:0] model_byte = 8'h3C;
    logic [7:0] model_sr   = 8'h3C;
    assign miso_w = loop_en  ? mosi_w      : 1'bz;
    assign miso_w = model_en ? model_sr[7] : 1'bz;

    spi_transceiver #(
        .DATA_W (8),
        .CFG_W  (8)
    ) dut (
        .i_sys_clk     (clk),
        .i_sys_rst     (rst_n),
        .i_data        (data_in),
        .i_data_config (cfg),
        .i_trans_en    (trans_en),
        .o_interrupt   (irq),
        .o_data        (data_out),
        .io_MOSI       (mosi_w),
        .io_MISO       (miso_w),
        .io_SCK        (sck_w),
        .io_SS         (ss_w)
    );

    always #5 clk = ~clk;

    // Pad monitor: cycle count, SCK rise timestamps, MOSI at SCK rise, IRQ pulses
    int         cyc      = 0;
    int         rises    = 0;
    int         t_prev   = 0;
    int         t_last   = 0;
    int         irq_cnt  = 0;
    logic [7:0] mosi_cap = 8'h00;
    logic       sck_old  = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (irq) irq_cnt++;
        if (sck_w && !sck_old) begin
            rises++;
            t_prev   = t_last;
            t_last   = cyc;
            mosi_cap = {mosi_cap[6:0], mosi_w};
        end
        if (ss_w) model_sr = model_byte;
        else if (!sck_w && sck_old) model_sr = {model_sr[6:0], 1'b0};
        sck_old = sck_w;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input logic [7:0] c);
        @(negedge clk);
        cfg = c;
        repeat (4) @(negedge clk);
    endtask

    task automatic start_xfer(input logic [7:0] d);
        @(negedge clk);
        data_in  = d;
        trans_en = 1'b1;
        @(negedge clk);
        trans_en = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc, input int base);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            if (irq_cnt != base) done = 1'b1;
        end
        check(tag, done, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic ext_master(input logic [7:0] tx, output logic [7:0] rx);
        rx      = 8'h00;
        tb_ss   = 1'b0;
        tb_mosi = tx[7];
        repeat (4) @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            rx     = {rx[6:0], miso_w};
            tb_sck = 1'b1;
            repeat (4) @(negedge clk);
            tb_sck = 1'b0;
            if (i > 0) tb_mosi = tx[i-1];
            repeat (4) @(negedge clk);
        end
        tb_ss = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base, r0;
        logic [7:0] rx;
        logic [7:0] mode_cfg [3];
        mode_cfg[0] = 8'hA9;
        mode_cfg[1] = 8'hC9;
        mode_cfg[2] = 8'hE9;

        rst_n    = 1'b0;
        cfg      = 8'h89;
        data_in  = 8'h00;
        trans_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_odata", data_out, 8'h00);
        check("rst_irq", irq, 0);
        check("rst_sck_z", sck_w, 1);
        check("rst_ss_z", ss_w, 1);
        check("rst_mosi_z", mosi_w, 1);
        check("rst_miso_z", miso_w, 1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_sck", sck_w, 0);
        check("idle_mosi", mosi_w, 0);

        // Master mode 0, /4, slave model returns 0x3C
        model_en = 1'b1;
        base     = irq_cnt;
        r0       = rises;
        start_xfer(8'hA5);
        wait_done("m0_done", 200, base);
        check("m0_odata", data_out, 8'h3C);
        check("m0_mosi", mosi_cap, 8'hA5);
        check("m0_rises", rises - r0, 8);
        check("m0_period", t_last - t_prev, 4);
        check("m0_ss_high", ss_w, 1);
        repeat (4) @(negedge clk);
        check("m0_irq_once", irq_cnt - base, 1);
        model_en = 1'b0;

        // Baud sweep with loopback
        loop_en = 1'b1;
        for (int sel = 0; sel < 8; sel++) begin
            set_cfg(8'h88 | 8'(sel));
            base = irq_cnt;
            start_xfer(8'hC3);
            wait_done("baud_done", 5000, base);
            check("baud_period", t_last - t_prev, 2 << sel);
        end

        // Modes 1..3, loopback
        for (int m = 0; m < 3; m++) begin
            set_cfg(mode_cfg[m]);
            base = irq_cnt;
            start_xfer(8'h5A);
            wait_done("mode_done", 300, base);
            check("mode_odata", data_out, 8'h5A);
            check("mode_idle_sck", sck_w, 32'(mode_cfg[m][6]));
        end
        loop_en = 1'b0;

        // Slave mode, external master at sys/8
        set_cfg(8'h08);
        check("slv_mosi_z", mosi_w, 1);
        check("slv_sck_z", sck_w, 1);
        tb_ss    = 1'b1;
        tb_sck   = 1'b0;
        tb_mosi  = 1'b0;
        tb_drive = 1'b1;
        data_in  = 8'h7E;
        trans_en = 1'b1;
        repeat (4) @(negedge clk);
        check("slv_miso_z_pre", miso_w, 1);
        base = irq_cnt;
        ext_master(8'h81, rx);
        trans_en = 1'b0;
        repeat (6) @(negedge clk);
        check("slv_miso_z_post", miso_w, 1);
        check("slv_odata", data_out, 8'h81);
        check("slv_master_rx", rx, 8'h7E);
        check("slv_irq_once", irq_cnt - base, 1);
        tb_drive = 1'b0;

        // Reset mid-transfer, then a clean transfer
        set_cfg(8'h89);
        model_en = 1'b1;
        base     = irq_cnt;
        start_xfer(8'h11);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_sck_z", sck_w, 1);
        check("mid_rst_ss_z", ss_w, 1);
        check("mid_rst_odata", data_out, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_rst_no_irq", irq_cnt - base, 0);
        check("mid_rst_odata_hold", data_out, 8'h00);
        base = irq_cnt;
        start_xfer(8'hA5);
        wait_done("post_rst_done", 200, base);
        check("post_rst_odata", data_out, 8'h3C);
        model_en = 1'b0;

`ifdef SPI_LSB_FIRST_EN
        loop_en = 1'b1;
        set_cfg(8'h99);
        base = irq_cnt;
        start_xfer(8'h01);
        wait_done("lsb_done", 200, base);
        check("lsb_mosi", mosi_cap, 8'h80);
        check("lsb_odata", data_out, 8'h01);
        loop_en = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
